// File: rtl/pointer_bank.sv
// pointer_bank: N_PTR byte-loadable address pointers with rotating logical-to-physical map and up/down stepping.
// Ports: nclk/rst (async active-low) clock and reset; di/n_we/w_idx/w_byte byte write;
//   addr_idx/n_oe_addr -> addr tri-state pointer; rd_idx/rd_byte/n_oe_data -> data_out tri-state byte;
//   cnt/cnt_idx/cnt_down pointer step; rot advances the map; wrap flags a step that crossed 0<->max.
module pointer_bank #(
  parameter int ADDR_W = 16,
  parameter int N_PTR = 4,
  localparam int NB = ADDR_W / 8,
  localparam int BSEL_W = (NB > 1) ? $clog2(NB) : 1,
  localparam int IDX_W = $clog2(N_PTR)
) (
  input  logic              nclk,
  input  logic              rst,
  input  logic [7:0]        di,
  input  logic              n_we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [BSEL_W-1:0] w_byte,
  input  logic [IDX_W-1:0]  addr_idx,
  input  logic              n_oe_addr,
  output logic [ADDR_W-1:0] addr,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BSEL_W-1:0] rd_byte,
  input  logic              n_oe_data,
  output logic [7:0]        data_out,
  input  logic              cnt,
  input  logic [IDX_W-1:0]  cnt_idx,
  input  logic              cnt_down,
  input  logic              rot,
  output logic              wrap
);
  localparam logic [BSEL_W:0] NB_L = NB[BSEL_W:0];
  logic [ADDR_W-1:0] r_ptr [N_PTR];
  logic [IDX_W-1:0]  r_off;
  logic              r_wrap;
  logic [IDX_W-1:0]  w_wp, w_cp, w_ap, w_rp;
  logic [ADDR_W-1:0] w_cur, w_nxt, w_mask, w_data, w_sh;
  logic              w_wr, w_step, w_carry;
  // logical-to-physical: N_PTR is a power of 2, so IDX_W-bit addition wraps modulo N_PTR
  assign w_wp = w_idx + r_off;
  assign w_cp = cnt_idx + r_off;
  assign w_ap = addr_idx + r_off;
  assign w_rp = rd_idx + r_off;
  assign w_wr = !n_we && ({1'b0, w_byte} < NB_L);
  // a write to the same physical pointer takes priority and cancels the step
  assign w_step = cnt && !(w_wr && w_wp == w_cp);
  assign w_cur = r_ptr[w_cp];
  assign w_nxt = cnt_down ? w_cur - 1'b1 : w_cur + 1'b1;
  assign w_carry = cnt_down ? (w_cur == '0) : (&w_cur);
  assign w_mask = ADDR_W'(8'hFF) << {w_byte, 3'b000};
  assign w_data = ADDR_W'(di) << {w_byte, 3'b000};
  assign w_sh = r_ptr[w_rp] >> {rd_byte, 3'b000};
  assign addr = n_oe_addr ? 'z : r_ptr[w_ap];
  assign data_out = n_oe_data ? 'z : (({1'b0, rd_byte} < NB_L) ? w_sh[7:0] : 8'h00);
  assign wrap = r_wrap;
  always_ff @(posedge nclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PTR; i++) r_ptr[i] <= '0;
      r_off <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_off <= r_off + IDX_W'(rot);
      r_wrap <= w_step && w_carry;
      if (w_step) r_ptr[w_cp] <= w_nxt;
      if (w_wr) r_ptr[w_wp] <= (r_ptr[w_wp] & ~w_mask) | w_data;
    end
  end
endmodule

// File: tb/tb_pointer_bank.sv
// tb_pointer_bank: scoreboard-driven check of pointer_bank loads, steps, wrap, rotation and reset.
module tb_pointer_bank;
  logic nclk = 0, rst = 0;
  logic [7:0] di = 0;
  logic n_we = 1, w_byte = 0, rd_byte = 0;
  logic [1:0] w_idx = 0, addr_idx = 0, rd_idx = 0, cnt_idx = 0;
  logic n_oe_addr = 1, n_oe_data = 1, cnt = 0, cnt_down = 0, rot = 0;
  wire [15:0] addr;
  wire [7:0] data_out;
  logic wrap;
  int n_chk = 0, n_fail = 0;
  typedef struct {string tag; int kind; int idx; int lane; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  pointer_bank dut (
    .nclk(nclk), .rst(rst), .di(di), .n_we(n_we), .w_idx(w_idx), .w_byte(w_byte),
    .addr_idx(addr_idx), .n_oe_addr(n_oe_addr), .addr(addr),
    .rd_idx(rd_idx), .rd_byte(rd_byte), .n_oe_data(n_oe_data), .data_out(data_out),
    .cnt(cnt), .cnt_idx(cnt_idx), .cnt_down(cnt_down), .rot(rot), .wrap(wrap)
  );
  always #5 nclk = ~nclk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic exp_addr(string t, int i, logic [31:0] v);
    sb.push_back('{t, 0, i, 0, v});
  endtask
  task automatic exp_data(string t, int i, int l, logic [31:0] v);
    sb.push_back('{t, 1, i, l, v});
  endtask
  task automatic exp_wrap(string t, logic [31:0] v);
    sb.push_back('{t, 2, 0, 0, v});
  endtask
  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0: begin
          addr_idx = e.idx[1:0];
          n_oe_addr = 0;
          #1 check(e.tag, {16'h0, addr}, e.exp);
          n_oe_addr = 1;
        end
        1: begin
          rd_idx = e.idx[1:0];
          rd_byte = e.lane[0];
          n_oe_data = 0;
          #1 check(e.tag, {24'h0, data_out}, e.exp);
          n_oe_data = 1;
        end
        default: #1 check(e.tag, {31'h0, wrap}, e.exp);
      endcase
    end
  endtask
  task automatic tick;
    @(posedge nclk);
    #1;
    n_we = 1;
    cnt = 0;
    rot = 0;
    drain();
  endtask
  task automatic wr(int i, int l, logic [7:0] v);
    @(negedge nclk);
    n_we = 0;
    w_idx = i[1:0];
    w_byte = l[0];
    di = v;
    tick();
  endtask
  task automatic load(int i, logic [15:0] v);
    wr(i, 0, v[7:0]);
    wr(i, 1, v[15:8]);
  endtask
  task automatic step(int i, logic down);
    @(negedge nclk);
    cnt = 1;
    cnt_idx = i[1:0];
    cnt_down = down;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    for (int i = 0; i < 4; i++) exp_addr($sformatf("rst_addr%0d", i), i, 0);
    exp_wrap("rst_wrap", 0);
    drain();
    #6 rst = 1;
    load(1, 16'h1234);
    exp_addr("ld_addr1", 1, 16'h1234);
    exp_data("ld_hi1", 1, 1, 8'h12);
    exp_data("ld_lo1", 1, 0, 8'h34);
    drain();
    load(0, 16'h00FF);
    step(0, 0);
    exp_wrap("carry_wrap", 0);
    exp_addr("carry_val", 0, 16'h0100);
    tick();
    load(0, 16'hFFFF);
    step(0, 0);
    exp_wrap("up_wrap", 1);
    exp_addr("up_val", 0, 16'h0000);
    tick();
    exp_wrap("up_wrap_clr", 0);
    tick();
    step(0, 1);
    exp_wrap("dn_wrap", 1);
    exp_addr("dn_val", 0, 16'hFFFF);
    tick();
    load(2, 16'h0100);
    step(2, 1);
    exp_wrap("borrow_wrap", 0);
    exp_addr("borrow_val", 2, 16'h00FF);
    tick();
    load(0, 16'h1111);
    load(1, 16'h2222);
    load(2, 16'h3333);
    load(3, 16'h4444);
    @(negedge nclk);
    rot = 1;
    exp_addr("rot1_l0", 0, 16'h2222);
    exp_addr("rot1_l3", 3, 16'h1111);
    exp_data("rot1_l1_hi", 1, 1, 8'h33);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge nclk);
      rot = 1;
      tick();
    end
    exp_addr("rot4_l0", 0, 16'h1111);
    exp_addr("rot4_l2", 2, 16'h3333);
    drain();
    load(0, 16'h0102);
    @(negedge nclk);
    n_we = 0; w_idx = 0; w_byte = 0; di = 8'hAA;
    cnt = 1; cnt_idx = 0; cnt_down = 0; rot = 1;
    exp_wrap("same_wrap", 0);
    exp_addr("same_l3", 3, 16'h01AA);
    exp_addr("same_l0", 0, 16'h2222);
    tick();
    @(negedge nclk);
    n_we = 0; w_idx = 0; w_byte = 1; di = 8'h55;
    cnt = 1; cnt_idx = 1; cnt_down = 0;
    exp_addr("diff_wr", 0, 16'h5522);
    exp_addr("diff_step", 1, 16'h3334);
    tick();
    load(0, 16'hFFFF);
    step(0, 0);
    exp_wrap("pre_rst_wrap", 1);
    tick();
    #1 rst = 0;
    exp_wrap("mid_rst_wrap", 0);
    exp_addr("mid_rst_l0", 0, 0);
    exp_addr("mid_rst_l1", 1, 0);
    drain();
    @(negedge nclk);
    n_we = 0; w_idx = 0; w_byte = 0; di = 8'h99;
    cnt = 1; cnt_idx = 1; rot = 1;
    @(posedge nclk);
    #1;
    n_we = 1; cnt = 0; rot = 0;
    #2 rst = 1;
    exp_addr("rst_ign_l0", 0, 0);
    exp_addr("rst_ign_l1", 1, 0);
    drain();
    wr(2, 0, 8'h5A);
    exp_addr("post_rst_l2", 2, 16'h005A);
    exp_data("post_rst_lo", 2, 0, 8'h5A);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pointer_bank.md
# pointer_bank

Parametrised successor of the two-entry IP/DP pointer pair. It holds `N_PTR` address pointers of `ADDR_W` bits, loaded a byte at a time from the internal data bus. Any pointer can be driven onto the address bus, and any byte of any pointer onto the ALU bus. A rotating logical-to-physical map generalises the old swap toggle, and per-cycle increment or decrement supports IP fetch and DP auto-index. The block sits between the internal data bus, the ALU B bus and the memory address bus, under control-unit strobes.

## Interface
Parameters:
- `ADDR_W`, 16, pointer width in bits; a multiple of 8, range 8..32. `NB = ADDR_W/8`; `BSEL_W = max(1, clog2(NB))`.
- `N_PTR`, 4, number of pointers; a power of 2, range 2..8. `IDX_W = log2(N_PTR)`.

Ports:
- `nclk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `di`  in  8  byte to load.
- `n_we`  in  1  active-low byte write strobe.
- `w_idx`  in  IDX_W  logical pointer to write.
- `w_byte`  in  BSEL_W  byte lane to write; 0 = LSB.
- `addr_idx`  in  IDX_W  logical pointer driven on `addr`.
- `n_oe_addr`  in  1  active-low enable for `addr`.
- `addr`  out  ADDR_W  tri-state address bus.
- `rd_idx`  in  IDX_W  logical pointer for byte read.
- `rd_byte`  in  BSEL_W  byte lane for read.
- `n_oe_data`  in  1  active-low enable for `data_out`.
- `data_out`  out  8  tri-state ALU-bus byte.
- `cnt`  in  1  step the pointer selected by `cnt_idx`.
- `cnt_idx`  in  IDX_W  logical pointer to step.
- `cnt_down`  in  1  0 = +1, 1 = −1.
- `rot`  in  1  advance the logical-to-physical map by one.
- `wrap`  out  1  registered; high for one cycle after a step crosses 0↔max.

## Operation
- Mapping: `phys(l) = (l + off) mod N_PTR`. `off` is an `IDX_W`-bit register that increments modulo `N_PTR` on `rot`. With `N_PTR=2`, this is exactly the swap toggle.
- Write: on an edge with `n_we`=0, byte `w_byte` of `phys(w_idx)` ← `di`. Other bytes are unchanged. `w_byte` ≥ NB is ignored (no write).
- Step: on an edge with `cnt`=1, `phys(cnt_idx)` ← value ±1, modulo 2^ADDR_W, with full carry/borrow across bytes.
- `wrap` is set to 1 if that step went max→0 (up) or 0→max (down). Otherwise it is set to 0 on every edge.
- Read paths are combinational from registers and current selects:
  - `addr` = `phys(addr_idx)` value when `n_oe_addr`=0, else Z.
  - `data_out` = selected byte when `n_oe_data`=0, else Z. `rd_byte` ≥ NB drives 0x00.
- Simultaneous events on the same edge:
  - All index decoding uses the pre-edge `off`. `rot` takes effect for the next cycle.
  - Write and step on the same physical pointer: write wins; the step is suppressed and `wrap`=0.
  - Write and step on different pointers: both occur.
- Reset (`rst`=0, asynchronous, any time including mid-cycle): all pointers = 0, `off` = 0, `wrap` = 0. All strobes are ignored while `rst`=0. Outputs remain governed only by the `n_oe_*` inputs, so the bus shows 0 when enabled.

## Timing
- Single-edge design: no internal state machine beyond the pointer registers, `off` and `wrap`.
- Write, step and rot latency: 1 edge. The new value is visible on `addr`/`data_out` after the rising `nclk` edge, combinational delay only.
- Select and enable changes reach the outputs combinationally in the same cycle. The control unit must not enable both the `addr` tri-state and another address driver.
- Strobes are sampled only at the rising `nclk` edge. They must be stable around it; the control unit changes them off the opposite clock phase.
- Release of `rst` is synchronous to nothing. The first usable edge is the first rising `nclk` after `rst` returns high.

## Test plan
- Reset, then `n_oe_addr`=0, `addr_idx`=0..3 → `addr`=0x0000 for each; `n_oe_addr`=1 → `addr`=Z.
- Write `di`=0x34 to byte 0 and 0x12 to byte 1 of pointer 1 → `addr_idx`=1 gives 0x1234; `rd_idx`=1, `rd_byte`=1 gives `data_out`=0x12.
- Load pointer 0 = 0x00FF, step up → 0x0100, `wrap`=0. Load 0xFFFF, step up → 0x0000, `wrap`=1 for exactly one cycle. Step down from 0x0000 → 0xFFFF, `wrap`=1.
- With pointers = {0x1111, 0x2222, 0x3333, 0x4444}, pulse `rot` once → `addr_idx`=0 reads 0x2222 and `addr_idx`=3 reads 0x1111. Four rots return to identity.
- Same edge: write `w_idx`=0 byte 0 = 0xAA, `cnt` on `cnt_idx`=0, `rot`=1, with pointer 0 = 0x0102 → physical 0 = 0x01AA, no increment; afterwards logical 3 reads 0x01AA.
- Assert `rst` between edges after loading non-zero values → `addr` reads 0 immediately; `wrap`=0; mapping is identity.
